// File: rtl/vector_pop_sequencer_if.sv
// Issue and functional-unit handshake bundle for the vector pop/parity sequencer.
// Signal names match the sequencer's documented port list.
interface vector_pop_sequencer_if #(
    parameter int unsigned VL_W  = 7,
    parameter int unsigned NVREG = 8
);
    logic              i_issue;
    logic [2:0]        i_op;
    logic [2:0]        i_j;
    logic [2:0]        i_i;
    logic [VL_W-1:0]   i_vl;
    logic [NVREG-1:0]  i_vreg_busy;
    logic              o_issue_ack;
    logic              o_start;
    logic [2:0]        o_unit_k;
    logic [2:0]        o_unit_j;
    logic              o_rd_en;
    logic [5:0]        o_rd_elem;
    logic              o_wr_en;
    logic [2:0]        o_wr_i;
    logic [5:0]        o_wr_elem;
    logic              o_fu_busy;
    logic [NVREG-1:0]  o_vreg_res;

    modport master (
        output i_issue, i_op, i_j, i_i, i_vl, i_vreg_busy,
        input  o_issue_ack, o_start, o_unit_k, o_unit_j, o_rd_en, o_rd_elem,
               o_wr_en, o_wr_i, o_wr_elem, o_fu_busy, o_vreg_res
    );

    modport slave (
        input  i_issue, i_op, i_j, i_i, i_vl, i_vreg_busy,
        output o_issue_ack, o_start, o_unit_k, o_unit_j, o_rd_en, o_rd_elem,
               o_wr_en, o_wr_i, o_wr_elem, o_fu_busy, o_vreg_res
    );
endinterface

// File: rtl/vector_pop_sequencer.sv
// Issue-side controller for the vector pop-count/parity unit: accepts an instruction,
// streams Vj element reads, and lines up Vi writes after the fixed unit latency.
module vector_pop_sequencer #(
    parameter int unsigned LATENCY = 5,
    parameter int unsigned VL_W    = 7,
    parameter int unsigned NVREG   = 8
) (
    input logic                   clk,
    input logic                   rst,
    vector_pop_sequencer_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

    localparam logic [NVREG-1:0] ResOne = {{(NVREG-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [2:0]         k_q, k_d, j_q, j_d, i_q, i_d;
    logic [6:0]         n_q, n_d;
    logic [5:0]         rd_cnt_q, rd_cnt_d;
    logic [5:0]         wr_cnt_q, wr_cnt_d;
    logic [NVREG-1:0]   res_q, res_d;
    logic [LATENCY-1:0] vld_q, vld_d;

    logic [VL_W-1:0] vl;
    logic [31:0]     vl_ext;
    logic [6:0]      n_eff;
    logic            op_ok, accept, rd_en, wr_en, last_rd, last_wr;

    assign vl     = bus.i_vl;
    assign vl_ext = 32'(vl);
    // Zero or oversize lengths run the full 64-element register.
    assign n_eff  = ((vl_ext == 32'd0) || (vl_ext > 32'd64)) ? 7'd64 : 7'(vl_ext);

    assign op_ok  = (bus.i_op == 3'b001) || (bus.i_op == 3'b010);
    assign accept = (state_q == StIdle) && bus.i_issue && op_ok &&
                    !bus.i_vreg_busy[bus.i_j] && !bus.i_vreg_busy[bus.i_i];

    assign rd_en   = (state_q == StRead);
    assign wr_en   = vld_q[LATENCY-1];
    assign last_rd = rd_en && ({1'b0, rd_cnt_q} == (n_q - 7'd1));
    assign last_wr = wr_en && ({1'b0, wr_cnt_q} == (n_q - 7'd1));

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        j_d      = j_q;
        i_d      = i_q;
        n_d      = n_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        res_d    = res_q;

        // Valid bits ride alongside the unit pipeline to time the writes.
        vld_d[0] = rd_en;
        for (int unsigned k = 1; k < LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d  = StRead;
                    k_d      = bus.i_op;
                    j_d      = bus.i_j;
                    i_d      = bus.i_i;
                    n_d      = n_eff;
                    rd_cnt_d = 6'd0;
                    wr_cnt_d = 6'd0;
                    res_d    = (ResOne << bus.i_j) | (ResOne << bus.i_i);
                end
            end
            StRead: begin
                if (last_rd) begin
                    state_d = StDrain;
                    // A shared source/destination bit stays until the last write.
                    if (j_q != i_q) begin
                        res_d = res_q & ~(ResOne << j_q);
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q + 6'd1;
                end
            end
            StDrain: ;
            default: state_d = StIdle;
        endcase

        if (wr_en && !last_wr) begin
            wr_cnt_d = wr_cnt_q + 6'd1;
        end
        if (last_wr) begin
            state_d = StIdle;
            res_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            k_q      <= 3'd0;
            j_q      <= 3'd0;
            i_q      <= 3'd0;
            n_q      <= 7'd0;
            rd_cnt_q <= 6'd0;
            wr_cnt_q <= 6'd0;
            res_q    <= '0;
            vld_q    <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            j_q      <= j_d;
            i_q      <= i_d;
            n_q      <= n_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            res_q    <= res_d;
            vld_q    <= vld_d;
        end
    end

    assign bus.o_issue_ack = accept;
    assign bus.o_start     = rd_en && (rd_cnt_q == 6'd0);
    assign bus.o_unit_k    = k_q;
    assign bus.o_unit_j    = j_q;
    assign bus.o_rd_en     = rd_en;
    assign bus.o_rd_elem   = rd_cnt_q;
    assign bus.o_wr_en     = wr_en;
    assign bus.o_wr_i      = i_q;
    assign bus.o_wr_elem   = wr_cnt_q;
    assign bus.o_fu_busy   = (state_q != StIdle);
    assign bus.o_vreg_res  = res_q;

endmodule

// File: tb/tb_vector_pop_sequencer.sv
// Directed bench for vector_pop_sequencer: table of single instructions plus
// hand-written busy-release, back-to-back and mid-operation reset sequences.
module tb_vector_pop_sequencer;

    localparam int unsigned LAT   = 5;
    localparam int unsigned VL_W  = 7;
    localparam int unsigned NVREG = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vector_pop_sequencer_if #(.VL_W(VL_W), .NVREG(NVREG)) bus ();

    vector_pop_sequencer #(.LATENCY(LAT), .VL_W(VL_W), .NVREG(NVREG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0] op;
        logic [2:0] j;
        logic [2:0] i;
        logic [6:0] vl;
        logic [7:0] busy;
        bit         exp_ack;
        int         exp_n;
        logic [7:0] exp_res;
        logic [7:0] exp_res_drain;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iss, input logic [2:0] op, input logic [2:0] j,
                         input logic [2:0] i, input logic [6:0] vl, input logic [7:0] busy);
        bus.i_issue     = iss;
        bus.i_op        = op;
        bus.i_j         = j;
        bus.i_i         = i;
        bus.i_vl        = vl;
        bus.i_vreg_busy = busy;
    endtask

    // Checks every cycle from T+1 to T+n+LAT+1 after an accept at edge T.
    task automatic timeline(input logic [2:0] op, input logic [2:0] j, input logic [2:0] i,
                            input int n, input logic [7:0] res, input logic [7:0] res_dr,
                            input bit hold);
        int wrs;
        bit rd_exp, wr_exp;
        logic [7:0] res_exp;
        wrs = 0;
        for (int cyc = 1; cyc <= n + int'(LAT) + 1; cyc++) begin
            @(negedge clk);
            #1;
            rd_exp  = (cyc <= n);
            wr_exp  = (cyc >= 1 + int'(LAT)) && (cyc <= n + int'(LAT));
            res_exp = (cyc <= n) ? res : ((cyc <= n + int'(LAT)) ? res_dr : 8'h00);
            chk("start", 32'(bus.o_start), (cyc == 1) ? 1 : 0);
            chk("rd_en", 32'(bus.o_rd_en), 32'(rd_exp));
            if (rd_exp) chk("rd_elem", 32'(bus.o_rd_elem), cyc - 1);
            chk("wr_en", 32'(bus.o_wr_en), 32'(wr_exp));
            if (wr_exp) begin
                chk("wr_elem", 32'(bus.o_wr_elem), cyc - 1 - int'(LAT));
                chk("wr_i", 32'(bus.o_wr_i), 32'(i));
            end
            if (bus.o_wr_en) wrs++;
            chk("fu_busy", 32'(bus.o_fu_busy), (cyc <= n + int'(LAT)) ? 1 : 0);
            chk("vreg_res", 32'(bus.o_vreg_res), 32'(res_exp));
            if (cyc <= n + int'(LAT)) begin
                chk("unit_k", 32'(bus.o_unit_k), 32'(op));
                chk("unit_j", 32'(bus.o_unit_j), 32'(j));
            end
            chk("issue_ack", 32'(bus.o_issue_ack), (hold && cyc == n + int'(LAT) + 1) ? 1 : 0);
        end
        chk("write_count", wrs, n);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        drive(1'b1, v.op, v.j, v.i, v.vl, v.busy);
        #1;
        chk("accept_ack", 32'(bus.o_issue_ack), 32'(v.exp_ack));
        if (v.exp_ack) begin
            @(posedge clk);
            #1;
            drive(1'b0, 3'd0, 3'd0, 3'd0, 7'd0, 8'h00);
            timeline(v.op, v.j, v.i, v.exp_n, v.exp_res, v.exp_res_drain, 1'b0);
        end else begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                #1;
                chk("reject_ack", 32'(bus.o_issue_ack), 0);
                chk("reject_busy", 32'(bus.o_fu_busy), 0);
                chk("reject_res", 32'(bus.o_vreg_res), 0);
            end
            drive(1'b0, 3'd0, 3'd0, 3'd0, 7'd0, 8'h00);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_seen;
        //            op      j     i     vl      busy   ack n   res    drain
        tbl[0] = '{3'b001, 3'd2, 3'd5, 7'd4,   8'h00, 1'b1, 4,  8'h24, 8'h20};
        tbl[1] = '{3'b010, 3'd1, 3'd6, 7'd0,   8'h00, 1'b1, 64, 8'h42, 8'h40};
        tbl[2] = '{3'b011, 3'd0, 3'd1, 7'd3,   8'h00, 1'b0, 0,  8'h00, 8'h00};
        tbl[3] = '{3'b001, 3'd3, 3'd3, 7'd2,   8'h00, 1'b1, 2,  8'h08, 8'h08};
        tbl[4] = '{3'b001, 3'd7, 3'd0, 7'd100, 8'h00, 1'b1, 64, 8'h81, 8'h01};
        tbl[5] = '{3'b001, 3'd1, 3'd4, 7'd5,   8'h10, 1'b0, 0,  8'h00, 8'h00};
        tbl[6] = '{3'b010, 3'd0, 3'd7, 7'd1,   8'h00, 1'b1, 1,  8'h81, 8'h80};
        tbl[7] = '{3'b000, 3'd2, 3'd3, 7'd4,   8'h00, 1'b0, 0,  8'h00, 8'h00};

        rst = 1'b1;
        drive(1'b0, 3'd0, 3'd0, 3'd0, 7'd0, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_start", 32'(bus.o_start), 0);
        chk("rst_rd_en", 32'(bus.o_rd_en), 0);
        chk("rst_wr_en", 32'(bus.o_wr_en), 0);
        chk("rst_busy", 32'(bus.o_fu_busy), 0);
        chk("rst_ack", 32'(bus.o_issue_ack), 0);
        chk("rst_res", 32'(bus.o_vreg_res), 0);
        chk("rst_unit_k", 32'(bus.o_unit_k), 0);
        chk("rst_wr_i", 32'(bus.o_wr_i), 0);
        rst = 1'b0;

        for (int t = 0; t < 8; t++) run_vec(tbl[t]);

        // Busy source register blocks accept until released; later busy changes are ignored.
        @(negedge clk);
        drive(1'b1, 3'b001, 3'd2, 3'd5, 7'd3, 8'h04);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("busy_block_ack", 32'(bus.o_issue_ack), 0);
            @(negedge clk);
        end
        bus.i_vreg_busy = 8'h00;
        #1;
        chk("busy_release_ack", 32'(bus.o_issue_ack), 1);
        @(posedge clk);
        #1;
        drive(1'b0, 3'd0, 3'd0, 3'd0, 7'd0, 8'hff);
        timeline(3'b001, 3'd2, 3'd5, 3, 8'h24, 8'h20, 1'b0);
        bus.i_vreg_busy = 8'h00;

        // Second instruction held through the busy period is taken on the first idle cycle.
        @(negedge clk);
        drive(1'b1, 3'b001, 3'd1, 3'd2, 7'd3, 8'h00);
        #1;
        chk("b2b_first_ack", 32'(bus.o_issue_ack), 1);
        @(posedge clk);
        #1;
        drive(1'b1, 3'b010, 3'd4, 3'd5, 7'd2, 8'h00);
        timeline(3'b001, 3'd1, 3'd2, 3, 8'h06, 8'h04, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 3'd0, 3'd0, 3'd0, 7'd0, 8'h00);
        timeline(3'b010, 3'd4, 3'd5, 2, 8'h30, 8'h20, 1'b0);

        // Reset sampled at the end of the third read cycle of a 10-element op.
        @(negedge clk);
        drive(1'b1, 3'b001, 3'd1, 3'd2, 7'd10, 8'h00);
        #1;
        chk("rst_op_ack", 32'(bus.o_issue_ack), 1);
        @(posedge clk);
        #1;
        drive(1'b0, 3'd0, 3'd0, 3'd0, 7'd0, 8'h00);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_op_rd_elem", 32'(bus.o_rd_elem), 2);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_rst_start", 32'(bus.o_start), 0);
        chk("mid_rst_rd_en", 32'(bus.o_rd_en), 0);
        chk("mid_rst_rd_elem", 32'(bus.o_rd_elem), 0);
        chk("mid_rst_wr_en", 32'(bus.o_wr_en), 0);
        chk("mid_rst_busy", 32'(bus.o_fu_busy), 0);
        chk("mid_rst_res", 32'(bus.o_vreg_res), 0);
        chk("mid_rst_unit_k", 32'(bus.o_unit_k), 0);
        chk("mid_rst_unit_j", 32'(bus.o_unit_j), 0);
        chk("mid_rst_wr_i", 32'(bus.o_wr_i), 0);
        rst = 1'b0;
        wr_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #1;
            if (bus.o_wr_en) wr_seen++;
        end
        chk("post_rst_writes", wr_seen, 0);
        run_vec(tbl[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
